// File: rtl/weight_fetch_pkg.sv
// weight_fetch_pkg: shared types, tile limits and lane helper for the weight fetch sequencer.
package weight_fetch_pkg;
  localparam int MAX_DIM = 8;
  localparam int DIM_W = $clog2(MAX_DIM + 1);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD} state_t;
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction
endpackage

// File: rtl/weight_row_packer.sv
// weight_row_packer: gathers returned buffer words into one zero-filled packed row.
module weight_row_packer
  import weight_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_clear,
  input  logic                          i_cap,
  input  logic [DIM_W-1:0]              i_cols,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic [MAX_DIM*DATA_WIDTH-1:0] o_lanes
);
  localparam int LW = $clog2(MAX_DIM * DATA_WIDTH);
  logic [DIM_W-1:0]              r_cnt;
  logic [MAX_DIM*DATA_WIDTH-1:0] r_lanes;
  // Clearing on every row start is what keeps lanes beyond the column count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_lanes <= '0;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_lanes <= '0;
    end else if (i_cap && r_cnt < i_cols) begin
      r_lanes[LW'(lane_lsb(32'(r_cnt), DATA_WIDTH)) +: DATA_WIDTH] <= i_data;
      r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_lanes = r_lanes;
endmodule

// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: walks a row-major weight tile, reading one word per cycle
// and presenting each packed row to the matrix unit over valid/ready.
module weight_fetch_ctrl
  import weight_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  logic [ADDR_WIDTH-1:0]         i_base_addr,
  input  logic [DIM_W-1:0]              i_num_rows,
  input  logic [DIM_W-1:0]              i_num_cols,
  input  logic [ADDR_WIDTH-1:0]         i_row_stride,
  input  logic                          i_abort,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err,
  output logic                          o_wb_rd_en,
  output logic [ADDR_WIDTH-1:0]         o_wb_rd_addr,
  input  logic [DATA_WIDTH-1:0]         i_wb_rd_data,
  input  logic                          i_wb_rd_valid,
  output logic                          o_row_valid,
  input  logic                          i_row_ready,
  output logic [MAX_DIM*DATA_WIDTH-1:0] o_row_data,
  output logic [DIM_W-1:0]              o_row_idx,
  output logic                          o_row_last
);
  state_t                r_state, w_next;
  logic [DIM_W-1:0]      r_rows, r_cols, r_row, r_col;
  logic [ADDR_WIDTH-1:0] r_stride, r_row_addr, r_rd_addr, w_rd_addr;
  logic                  r_rd_en, r_pend, r_done, r_err;
  logic                  w_legal, w_accept, w_hs, w_last_row, w_cap, w_rd_en, w_clear;
  assign w_legal    = i_num_rows != '0 && i_num_rows <= DIM_W'(MAX_DIM) &&
                      i_num_cols != '0 && i_num_cols <= DIM_W'(MAX_DIM);
  assign w_accept   = r_state == S_IDLE && i_start && w_legal && !i_abort;
  assign w_hs       = r_state == S_HOLD && i_row_ready && !i_abort;
  assign w_last_row = r_row == r_rows - 1'b1;
  // Only a word answering a read still owned by this tile may be packed.
  assign w_cap      = i_wb_rd_valid && r_pend;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_rd_addr = r_rd_addr;
    w_clear   = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_next    = S_FETCH;
        w_rd_en   = 1'b1;
        w_rd_addr = i_base_addr;
        w_clear   = 1'b1;
      end
      S_FETCH: if (r_col == r_cols - 1'b1) w_next = S_DRAIN;
      else begin
        w_rd_en   = 1'b1;
        w_rd_addr = r_row_addr + ADDR_WIDTH'(r_col + 1'b1);
      end
      S_DRAIN: if (w_cap) w_next = S_HOLD;
      S_HOLD: if (i_row_ready) begin
        w_next    = w_last_row ? S_IDLE : S_FETCH;
        w_rd_en   = !w_last_row;
        w_rd_addr = w_last_row ? r_rd_addr : r_row_addr + r_stride;
        w_clear   = !w_last_row;
      end
    endcase
    if (i_abort) begin
      w_next  = S_IDLE;
      w_rd_en = 1'b0;
      w_clear = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows     <= '0;
      r_cols     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_stride   <= '0;
      r_row_addr <= '0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_pend     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_en   <= w_rd_en;
      r_rd_addr <= w_rd_addr;
      r_pend    <= r_rd_en && !i_abort;
      r_done    <= w_hs && w_last_row;
      r_err     <= r_state == S_IDLE && i_start && !w_legal && !i_abort;
      if (w_accept) begin
        r_rows     <= i_num_rows;
        r_cols     <= i_num_cols;
        r_stride   <= i_row_stride;
        r_row      <= '0;
        r_col      <= '0;
        r_row_addr <= i_base_addr;
      end else if (r_state == S_FETCH) begin
        r_col <= r_col + 1'b1;
      end else if (w_hs && !w_last_row) begin
        r_row      <= r_row + 1'b1;
        r_col      <= '0;
        r_row_addr <= r_row_addr + r_stride;
      end
    end
  end
  weight_row_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_clear),
    .i_cap   (w_cap),
    .i_cols  (r_cols),
    .i_data  (i_wb_rd_data),
    .o_lanes (o_row_data)
  );
  assign o_busy       = r_state != S_IDLE;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_wb_rd_en   = r_rd_en;
  assign o_wb_rd_addr = r_rd_addr;
  assign o_row_valid  = r_state == S_HOLD;
  assign o_row_idx    = r_row;
  assign o_row_last   = o_row_valid && w_last_row;
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// tb_weight_fetch_ctrl: directed bench with a behavioural weight buffer (mem[a] = a)
// and a per-cycle model of read windows, row timing and packed row contents.
module tb_weight_fetch_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, abort = 1'b0, row_ready = 1'b1;
  logic [9:0]   base_addr = '0, row_stride = '0;
  logic [3:0]   num_rows = '0, num_cols = '0;
  logic         busy, done, err, wb_rd_en, wb_rd_valid = 1'b0, row_valid, row_last;
  logic [9:0]   wb_rd_addr;
  logic [15:0]  wb_rd_data = '0;
  logic [127:0] row_data;
  logic [3:0]   row_idx;
  int           checks = 0, failures = 0, dcyc;

  always #5 clk = ~clk;

  weight_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_num_rows(num_rows), .i_num_cols(num_cols), .i_row_stride(row_stride),
    .i_abort(abort), .o_busy(busy), .o_done(done), .o_err(err),
    .o_wb_rd_en(wb_rd_en), .o_wb_rd_addr(wb_rd_addr), .i_wb_rd_data(wb_rd_data),
    .i_wb_rd_valid(wb_rd_valid), .o_row_valid(row_valid), .i_row_ready(row_ready),
    .o_row_data(row_data), .o_row_idx(row_idx), .o_row_last(row_last)
  );

  // Synchronous-read buffer: one cycle latency, contents equal to the address.
  always @(posedge clk) begin
    wb_rd_valid <= wb_rd_en;
    wb_rd_data  <= 16'(wb_rd_addr);
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_row(input int base, input int r, input int cols, input int stride);
    logic [127:0] v = '0;
    for (int c = 0; c < 8; c++)
      if (c < cols) v[c*16 +: 16] = 16'((base + r*stride + c) % 1024);
    return v;
  endfunction

  // Caller is just past a negedge with the DUT idle; start is sampled at the coming edge (cycle 0).
  task automatic run_tile(input int base, input int rows, input int cols, input int stride,
                          input int stall_len, input bit poke, output int done_cyc);
    int cyc = 1, r = 0, rd_start = 1, exp_rv = cols + 2, stall = stall_len, ndone = 0, done_exp = -1;
    bit seen = 0, fin = 0, in_win;
    base_addr = 10'(base); num_rows = 4'(rows); num_cols = 4'(cols); row_stride = 10'(stride);
    start = 1'b1; row_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cyc = -1;
    while (!fin && cyc < 300) begin
      in_win = cyc >= rd_start && cyc < rd_start + cols;
      chk("rd_en", wb_rd_en, in_win);
      if (wb_rd_en && in_win) chk("rd_addr", wb_rd_addr, (base + r*stride + cyc - rd_start) % 1024);
      if (done) ndone++;
      if (cyc == done_exp) begin
        chk("done", done, 1);
        chk("busy_at_done", busy, 0);
        chk("row_valid_at_done", row_valid, 0);
        done_cyc = cyc;
        fin = 1;
      end else begin
        chk("busy", busy, 1);
        if (row_valid) begin
          if (!seen) begin chk("rv_cycle", cyc, exp_rv); seen = 1; end
          chk("row_data", row_data, exp_row(base, r, cols, stride));
          chk("row_idx", row_idx, r);
          chk("row_last", row_last, r == rows - 1);
          if (r == 0 && stall > 0) begin row_ready = 1'b0; stall--; end
          else row_ready = 1'b1;
          if (row_ready) begin
            if (r == rows - 1) done_exp = cyc + 1;
            else begin r++; rd_start = cyc + 1; exp_rv = cyc + cols + 2; seen = 0; end
          end
        end else row_ready = 1'b1;
        if (poke && cyc == 3) begin start = 1'b1; base_addr = 10'd500; num_rows = 4'd1; end
        else start = 1'b0;
      end
      if (!fin) begin @(negedge clk); cyc++; end
    end
    start = 1'b0; row_ready = 1'b1;
    if (!fin) chk("tile_timeout", 0, 1);
    chk("done_count", ndone, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_en", wb_rd_en, 0);
    chk("rst_rd_addr", wb_rd_addr, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_row_data", row_data, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_row_last", row_last, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_tile(0, 8, 8, 8, 0, 0, dcyc);
    chk("full_tile_done_cycle", dcyc, 81);
    run_tile(1020, 2, 3, 4, 0, 0, dcyc);
    chk("wrap_tile_done_cycle", dcyc, 11);
    run_tile(0, 2, 4, 8, 5, 0, dcyc);
    chk("stall_tile_done_cycle", dcyc, 18);

    num_rows = 4'd4; num_cols = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_cols0", err, 1);
    chk("err_cols0_busy", busy, 0);
    chk("err_cols0_rd_en", wb_rd_en, 0);
    @(negedge clk);
    chk("err_cols0_pulse", err, 0);
    chk("err_cols0_rd_en2", wb_rd_en, 0);
    num_rows = 4'd9; num_cols = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err_rows9", err, 1);
    chk("err_rows9_busy", busy, 0);
    chk("err_rows9_rd_en", wb_rd_en, 0);
    @(negedge clk);
    chk("err_rows9_pulse", err, 0);
    chk("err_rows9_busy2", busy, 0);
    run_tile(16, 1, 2, 8, 0, 0, dcyc);
    chk("after_err_done_cycle", dcyc, 5);

    base_addr = 10'd0; num_rows = 4'd4; num_cols = 4'd4; row_stride = 10'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort_pre_busy", busy, 1);
    chk("abort_pre_rd_en", wb_rd_en, 1);
    chk("abort_pre_addr", wb_rd_addr, 17);
    chk("abort_pre_idx", row_idx, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_row_valid", row_valid, 0);
    chk("abort_rd_en", wb_rd_en, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    run_tile(40, 1, 2, 8, 0, 0, dcyc);
    chk("post_abort_done_cycle", dcyc, 5);

    run_tile(200, 3, 2, 8, 0, 1, dcyc);
    chk("poke_done_cycle", dcyc, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
